// File: rtl/regfile_scoreboard.sv
// Integer register file with x0 tied to zero, bypassed read ports
// and a per-register busy scoreboard that stalls decode on RAW/WAW.
module regfile_scoreboard #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  localparam int NREG = 2**AW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   ra1,
  output logic [XLEN-1:0] rd1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd2,
  input  logic            iss_valid,
  input  logic            iss_wr,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic [NREG-1:0] wen_onehot
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busyQ;
  logic [NREG-1:0] clrVec;
  logic [NREG-1:0] setVec;
  logic [NREG-1:0] busyEff;

  function automatic logic [XLEN-1:0] readPort(
    input logic [AW-1:0] ra
  );
    if (ra == '0)
      return '0;
    else if (we && wa == ra)
      return wd;
    else
      return regs[ra];
  endfunction

  always_comb begin
    wen_onehot = '0;
    if (we)
      wen_onehot = (NREG'(1) << wa) & ~NREG'(1);
  end

  // A writeback this cycle releases its register before hazards are judged.
  always_comb begin
    clrVec  = wen_onehot;
    busyEff = busyQ & ~clrVec;
    stall   = iss_valid
            && (busyEff[iss_rs1] || busyEff[iss_rs2]
                || (iss_wr && busyEff[iss_rd]));
    setVec  = '0;
    if (iss_valid && iss_wr && !stall)
      setVec = (NREG'(1) << iss_rd) & ~NREG'(1);
  end

  always_comb begin
    rd1 = readPort(ra1);
    rd2 = readPort(ra2);
  end

  assign busy = busyQ;

  // Set wins over clear: the new owner issued after the old writeback.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
      busyQ <= '0;
    end else begin
      if (wen_onehot != '0)
        regs[wa] <= wd;
      busyQ <= setVec | (busyQ & ~clrVec);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: a 32/5 and a 64/6 instance share stimulus and are
// checked against an array-based register file model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [5:0]  wa;
  logic [63:0] wd;
  logic [5:0]  ra1;
  logic [5:0]  ra2;
  logic        issValid;
  logic        issWr;
  logic [5:0]  issRd;
  logic [5:0]  issRs1;
  logic [5:0]  issRs2;

  logic [31:0] rd1A, rd2A, busyA, wenA;
  logic        stallA;
  logic [63:0] rd1B, rd2B, busyB, wenB;
  logic        stallB;

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .AW(5)) uA (
    .clk(clk), .reset(reset), .we(we), .wa(wa[4:0]), .wd(wd[31:0]),
    .ra1(ra1[4:0]), .rd1(rd1A), .ra2(ra2[4:0]), .rd2(rd2A),
    .iss_valid(issValid), .iss_wr(issWr), .iss_rd(issRd[4:0]),
    .iss_rs1(issRs1[4:0]), .iss_rs2(issRs2[4:0]),
    .stall(stallA), .busy(busyA), .wen_onehot(wenA)
  );

  regfile_scoreboard #(.XLEN(64), .AW(6)) uB (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .rd1(rd1B), .ra2(ra2), .rd2(rd2B),
    .iss_valid(issValid), .iss_wr(issWr), .iss_rd(issRd),
    .iss_rs1(issRs1), .iss_rs2(issRs2),
    .stall(stallB), .busy(busyB), .wen_onehot(wenB)
  );

  typedef struct {
    int          cfg;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] busy;
    logic [63:0] wen;
    logic        stall;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [63:0] mReg  [2][64];
  bit          mBusy [2][64];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model one configuration for the inputs currently on the pins.
  task automatic modelStep(input int c, input bit push);
    int n;
    int a, r1, r2, rd, s1, s2;
    logic [63:0] dm, d;
    bit pend [64];
    exp_t e;
    n  = c ? 64 : 32;
    dm = c ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a  = int'(wa) % n;
    r1 = int'(ra1) % n;
    r2 = int'(ra2) % n;
    rd = int'(issRd) % n;
    s1 = int'(issRs1) % n;
    s2 = int'(issRs2) % n;
    d  = wd & dm;
    for (int i = 0; i < 64; i++)
      pend[i] = (i != 0) && (i < n) && mBusy[c][i] && !(we && a == i);
    e.cfg   = c;
    e.rd1   = (r1 == 0) ? 64'd0 : (we && a == r1) ? d : mReg[c][r1];
    e.rd2   = (r2 == 0) ? 64'd0 : (we && a == r2) ? d : mReg[c][r2];
    e.wen   = (we && a != 0) ? (64'd1 << a) : 64'd0;
    e.stall = issValid && (pend[s1] || pend[s2] || (issWr && pend[rd]));
    e.busy  = 64'd0;
    for (int i = 0; i < n; i++)
      if (mBusy[c][i]) e.busy[i] = 1'b1;
    if (push) q.push_back(e);
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        mReg[c][i]  = 64'd0;
        mBusy[c][i] = 1'b0;
      end
    end else begin
      if (we && a != 0) begin
        mReg[c][a]  = d;
        mBusy[c][a] = 1'b0;
      end
      if (issValid && issWr && !e.stall && rd != 0)
        mBusy[c][rd] = 1'b1;
    end
  endtask

  task automatic cyc(input bit r, input bit w, input int a,
                     input logic [63:0] d, input int p1, input int p2,
                     input bit v, input bit iw, input int rd,
                     input int s1, input int s2, input bit push = 1'b1);
    @(posedge clk);
    #1;
    reset    = r;
    we       = w;
    wa       = 6'(a);
    wd       = d;
    ra1      = 6'(p1);
    ra2      = 6'(p2);
    issValid = v;
    issWr    = iw;
    issRd    = 6'(rd);
    issRs1   = 6'(s1);
    issRs2   = 6'(s2);
    modelStep(0, push);
    modelStep(1, push);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.cfg == 0) begin
          chk("rd1_x32", {32'd0, rd1A}, e.rd1);
          chk("rd2_x32", {32'd0, rd2A}, e.rd2);
          chk("wen_x32", {32'd0, wenA}, e.wen);
          chk("busy_x32", {32'd0, busyA}, e.busy);
          chk("stall_x32", {63'd0, stallA}, {63'd0, e.stall});
        end else begin
          chk("rd1_x64", rd1B, e.rd1);
          chk("rd2_x64", rd2B, e.rd2);
          chk("wen_x64", wenB, e.wen);
          chk("busy_x64", busyB, e.busy);
          chk("stall_x64", {63'd0, stallB}, {63'd0, e.stall});
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [63:0] rnd;
    int sel;
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    issValid = 1'b0; issWr = 1'b0; issRd = '0; issRs1 = '0; issRs2 = '0;
    for (int i = 0; i < 64; i++) begin
      mReg[0][i] = 64'd0; mReg[1][i] = 64'd0;
      mBusy[0][i] = 1'b0; mBusy[1][i] = 1'b0;
    end
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // bypass then array read
    cyc(0, 1, 5, 64'hDEADBEEF, 5, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 5, 5, 0, 0, 0, 0, 0);
    // x0 write dropped
    cyc(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0);
    // RAW on x7 released by same-cycle writeback
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 7, 0, 1, 0, 0, 7, 0);
    cyc(0, 1, 7, 64'h1234_5678_9ABC_DEF0, 7, 0, 1, 0, 0, 7, 0);
    cyc(0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0);
    // set beats clear on x3
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 3, 0, 0);
    cyc(0, 1, 3, 64'hCAFE_F00D, 3, 0, 1, 1, 3, 0, 0);
    cyc(0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    // WAW on x9, then reset mid-flight
    cyc(0, 1, 9, 64'h55, 0, 0, 1, 1, 9, 0, 0);
    cyc(0, 0, 0, 0, 9, 0, 1, 1, 9, 0, 0);
    cyc(0, 0, 0, 0, 9, 3, 1, 1, 9, 0, 0);
    cyc(1, 1, 10, 64'h77, 9, 3, 1, 1, 11, 0, 0);
    cyc(0, 0, 0, 0, 9, 10, 1, 1, 9, 3, 11);
    // write to a non-busy register, and bit 63/31 boundaries
    cyc(0, 1, 63, 64'h8000_0000_0000_0001, 63, 31, 0, 0, 0, 0, 0);
    cyc(0, 1, 31, 64'hFFFF_0000_FFFF_0000, 63, 31, 1, 1, 63, 31, 0);
    cyc(0, 0, 0, 0, 63, 31, 1, 0, 0, 63, 31);
    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 3));
      rnd = {$urandom(), $urandom()};
      cyc(($urandom_range(0, 59) == 0),
          $urandom_range(0, 1) == 1,
          (sel == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7)),
          rnd,
          int'($urandom_range(0, 7)),
          (sel == 1) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1,
          int'($urandom_range(0, 7)),
          int'($urandom_range(0, 7)),
          (sel == 2) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7)));
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
